// File: rtl/integral_term_pkg.sv
// Shared widths and sequencer state encoding for the integral-term unit.
package integral_term_pkg;

   localparam int unsigned DATA_W = 16;  // width of e_k, Ki and i_k
   localparam int unsigned FRAC_W = 8;   // fractional bits of Ki

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StMul   = 3'd1,
      StScale = 3'd2,
      StAcc   = 3'd3,
      StDone  = 3'd4
   } state_t;

endpackage

// File: rtl/integral_term_if.sv
// Sample/result bundle between the PID controller and the integral-term unit.
interface integral_term_if #(
   parameter int unsigned N = 16
);
   logic signed [N-1:0] ek;
   logic                start;
   logic                clr;
   logic signed [N-1:0] ik;
   logic                busy;
   logic                done;

   modport master (output ek, start, clr, input ik, busy, done);
   modport slave  (input ek, start, clr, output ik, busy, done);
endinterface

// File: rtl/integral_term_saturador.sv
// Signed width-reduction clamp: IN_W bits down to OUT_W bits.
module integral_term_saturador #(
   parameter int unsigned IN_W  = 32,
   parameter int unsigned OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout
);

   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

   // The value fits when every dropped bit equals the new sign bit.
   always_comb begin
      dout = din[OUT_W-1:0];
      if (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[OUT_W-1]}}) begin
         dout = din[IN_W-1] ? OUT_MIN : OUT_MAX;
      end
   end

endmodule

// File: rtl/integral_term.sv
// Integral term of the PID datapath: i_k = clamp(i_{k-1} + sat(Ki*e_k >>> F)).
module integral_term
   import integral_term_pkg::*;
#(
   parameter int unsigned         N    = DATA_W,
   parameter int unsigned         F    = FRAC_W,
   parameter logic signed [N-1:0] KI   = 16'sd20,
   parameter logic signed [N-1:0] IMAX = 16'sd32767,
   parameter logic signed [N-1:0] IMIN = -16'sd32768
) (
   input logic            clk,
   input logic            reset,
   integral_term_if.slave bus
);

   state_t state_q, state_d;

   logic signed [N-1:0]   e_q;
   logic signed [2*N-1:0] p_q;
   logic signed [N-1:0]   s_q;
   logic signed [N-1:0]   ik_q;

   logic signed [2*N-1:0] e_ext, ki_ext, prod, p_shift;
   logic signed [N-1:0]   s_sat;
   logic signed [N:0]     sum, imax_ext, imin_ext;
   logic signed [N-1:0]   ik_next;

   assign e_ext   = (2*N)'(e_q);
   assign ki_ext  = (2*N)'(KI);
   assign prod    = e_ext * ki_ext;
   assign p_shift = p_q >>> F;  // floor toward -inf, no rounding

   integral_term_saturador #(
      .IN_W  (2*N),
      .OUT_W (N)
   ) u_sat (
      .din  (p_shift),
      .dout (s_sat)
   );

   assign sum      = (N+1)'(ik_q) + (N+1)'(s_q);
   assign imax_ext = (N+1)'(IMAX);
   assign imin_ext = (N+1)'(IMIN);

   // Anti-windup clamp of the one-bit-wider sum.
   always_comb begin
      ik_next = sum[N-1:0];
      if (sum > imax_ext) begin
         ik_next = IMAX;
      end else if (sum < imin_ext) begin
         ik_next = IMIN;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; clr wins over everything, start only counts in IDLE/DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StMul;
         StMul:   state_d = StScale;
         StScale: state_d = StAcc;
         StAcc:   state_d = StDone;
         StDone:  state_d = bus.start ? StMul : StIdle;
         default: state_d = StIdle;
      endcase
      if (bus.clr) begin
         state_d = StIdle;
      end
   end

   // Datapath registers, each loaded in its own sequencer step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         e_q  <= '0;
         p_q  <= '0;
         s_q  <= '0;
         ik_q <= '0;
      end else if (bus.clr) begin
         e_q  <= '0;
         p_q  <= '0;
         s_q  <= '0;
         ik_q <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: if (bus.start) e_q <= bus.ek;
            StMul:          p_q  <= prod;
            StScale:        s_q  <= s_sat;
            StAcc:          ik_q <= ik_next;
            default:        ;
         endcase
      end
   end

   // Moore outputs decoded from state.
   always_comb begin
      bus.ik   = ik_q;
      bus.busy = (state_q == StMul) || (state_q == StScale) || (state_q == StAcc);
      bus.done = (state_q == StDone);
   end

endmodule

// File: tb/tb_integral_term.sv
// Self-checking bench: three parameterisations driven by shared stimulus,
// checked every cycle against a sample-level reference model.
module tb_integral_term;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic signed [15:0] ek = '0;
   logic start = 1'b0;
   logic clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   // A: defaults, B: KI=32767, C: IMAX=1000
   integral_term_if #(.N(16)) bus_a ();
   integral_term_if #(.N(16)) bus_b ();
   integral_term_if #(.N(16)) bus_c ();

   assign bus_a.ek = ek;  assign bus_a.start = start;  assign bus_a.clr = clr;
   assign bus_b.ek = ek;  assign bus_b.start = start;  assign bus_b.clr = clr;
   assign bus_c.ek = ek;  assign bus_c.start = start;  assign bus_c.clr = clr;

   integral_term dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
   integral_term #(.KI(16'sd32767)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
   integral_term #(.IMAX(16'sd1000)) dut_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

   logic signed [15:0] ik_o [3];
   logic               busy_o [3];
   logic               done_o [3];
   assign ik_o[0] = bus_a.ik;  assign busy_o[0] = bus_a.busy;  assign done_o[0] = bus_a.done;
   assign ik_o[1] = bus_b.ik;  assign busy_o[1] = bus_b.busy;  assign done_o[1] = bus_b.done;
   assign ik_o[2] = bus_c.ik;  assign busy_o[2] = bus_c.busy;  assign done_o[2] = bus_c.done;

   longint kiv  [3] = '{20, 32767, 20};
   longint imaxv[3] = '{32767, 32767, 1000};
   longint iminv[3] = '{-32768, -32768, -32768};

   // Model: cycles since the sample was accepted (0 = idle, 4 = result shown).
   int     m_age [3];
   longint m_e   [3];
   longint m_ik  [3];

   function automatic longint next_ik(longint ikv, longint ev, longint kv,
                                      longint imx, longint imn);
      longint p, s, t;
      p = ev * kv;
      s = p / 256;
      if (p < 0 && (p % 256) != 0) s = s - 1;  // floor, not truncation
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      t = ikv + s;
      if (t > imx) t = imx;
      if (t < imn) t = imn;
      return t;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int k = 0; k < 3; k++) begin
         if (reset || clr) begin
            m_age[k] <= 0;
            m_e[k]   <= 0;
            m_ik[k]  <= 0;
         end else if (m_age[k] == 0 || m_age[k] == 4) begin
            if (start) begin
               m_age[k] <= 1;
               m_e[k]   <= longint'(ek);
            end else begin
               m_age[k] <= 0;
            end
         end else if (m_age[k] == 3) begin
            m_age[k] <= 4;
            m_ik[k]  <= next_ik(m_ik[k], m_e[k], kiv[k], imaxv[k], iminv[k]);
         end else begin
            m_age[k] <= m_age[k] + 1;
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every cycle once out of reset.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("ik[%0d]", k), longint'(ik_o[k]), m_ik[k]);
            chk($sformatf("busy[%0d]", k), longint'(busy_o[k]),
                longint'(m_age[k] >= 1 && m_age[k] <= 3));
            chk($sformatf("done[%0d]", k), longint'(done_o[k]), longint'(m_age[k] == 4));
         end
      end
   end

   // One sample from IDLE; check done and ik in cycle 4 against literals.
   task automatic sample(input logic signed [15:0] v, input longint ea,
                         input longint eb, input longint ec);
      @(negedge clk); #1; start = 1'b1; ek = v;
      @(negedge clk); #1; start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("lit_done_c4", longint'(bus_a.done), 1);
      chk("lit_ik_a", longint'(bus_a.ik), ea);
      chk("lit_ik_b", longint'(bus_b.ik), eb);
      chk("lit_ik_c", longint'(bus_c.ik), ec);
   endtask

   task automatic pulse_clr();
      @(negedge clk); #1; clr = 1'b1;
      @(negedge clk); #1; clr = 1'b0;
   endtask

   int cnt;

   initial begin
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_ik", longint'(bus_a.ik), 0);
      chk("rst_busy", longint'(bus_a.busy), 0);
      chk("rst_done", longint'(bus_a.done), 0);

      // Basic accumulation.
      sample(16'sd256, 20, 32767, 20);
      sample(16'sd256, 40, 32767, 40);
      // Floor behaviour.
      pulse_clr();
      sample(16'sd13, 1, 1663, 1);
      sample(-16'sd13, -1, -1, -1);
      // Scale saturation (B) and anti-windup (C).
      pulse_clr();
      sample(16'sd32767, 2559, 32767, 1000);
      sample(16'sd32767, 5118, 32767, 1000);
      sample(-16'sd256, 5098, 0, 980);

      // Back-to-back with start held: done every 4 cycles.
      @(negedge clk); #1; start = 1'b1; ek = 16'sd5;
      cnt = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (bus_a.done) cnt++;
      end
      #1 start = 1'b0;
      chk("b2b_done_count", cnt, 4);
      repeat (4) @(negedge clk);

      // Start pulse during SCALE is ignored.
      #1 start = 1'b1; ek = 16'sd7;
      cnt = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus_a.done) cnt++;
         #1 start = (i == 2);
      end
      chk("scale_start_ignored", cnt, 1);

      // clr in SCALE with ik=40.
      pulse_clr();
      sample(16'sd256, 20, 32767, 20);
      sample(16'sd256, 40, 32767, 40);
      @(negedge clk); #1; start = 1'b1; ek = 16'sd256;
      @(negedge clk); #1; start = 1'b0;
      @(negedge clk); #1; clr = 1'b1;
      @(negedge clk); #1; clr = 1'b0;
      chk("clr_ik", longint'(bus_a.ik), 0);
      chk("clr_busy", longint'(bus_a.busy), 0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_a.done) cnt++;
      end
      chk("clr_no_done", cnt, 0);

      // Async reset in ACC.
      sample(16'sd256, 20, 32767, 20);
      @(negedge clk); #1; start = 1'b1; ek = 16'sd256;
      @(negedge clk); #1; start = 1'b0;
      @(negedge clk);
      @(negedge clk); #1; reset = 1'b1;
      #1;
      chk("rst_acc_ik", longint'(bus_a.ik), 0);
      chk("rst_acc_busy", longint'(bus_a.busy), 0);
      chk("rst_acc_done", longint'(bus_a.done), 0);
      @(negedge clk); #1; reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_a.done) cnt++;
      end
      chk("rst_no_done", cnt, 0);

      // Randomised traffic.
      for (int i = 0; i < 600; i++) begin
         @(negedge clk); #1;
         start = ($urandom_range(0, 1) == 1);
         if ($urandom_range(0, 3) == 0) ek = 16'($urandom);
         else ek = 16'($signed($urandom_range(0, 1200)) - 600);
         clr = ($urandom_range(0, 47) == 0);
      end
      @(negedge clk); #1; start = 1'b0; clr = 1'b0;
      repeat (6) @(negedge clk);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
